butterfly_operand_tx: RTL and testbench

BUTTERFLY_OPERAND_TX -- requirements
Module: butterfly_operand_tx

---
 rtl/butterfly_pkg.sv | 26 ++
 rtl/operand_fifo.sv | 57 +++++
 rtl/butterfly_operand_tx.sv | 158 +++++++++++++++
 tb/tb_butterfly_operand_tx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/butterfly_pkg.sv
// butterfly_pkg: shared state type, operand width and default timing for the
// butterfly operand transmitter.
package butterfly_pkg;

    localparam int OPERAND_W           = 8;
    localparam int DEF_FIFO_DEPTH      = 8;
    localparam int DEF_SETUP_CYCLES    = 2;
    localparam int DEF_HOLD_CYCLES     = 16;
    localparam int DEF_GAP_CYCLES      = 16;
    localparam int DEF_WORDS_PER_FRAME = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

    // Largest of three timing values; sizes the shared phase down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/operand_fifo.sv
// operand_fifo: power-of-two circular buffer holding operands waiting for the
// transmitter. The head word is always visible on rd_data.
module operand_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;
    assign rd_data = mem[rd_ptr];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; clear empties the buffer and drops a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/butterfly_operand_tx.sv
// butterfly_operand_tx: buffers operands and presents them one at a time to the
// butterfly with a setup / ready-pulse / gap handshake, tracking frame position.
// Optional feature: define BUTTERFLY_TX_FLUSH_EN to add the flush input.
//
// state | meaning
// IDLE  | waiting for an operand; pops the FIFO head into tx_data
// SETUP | tx_data stable, tx_ready still low
// HOLD  | tx_ready high
// GAP   | tx_ready low, enforced recovery before the next word
module butterfly_operand_tx
    import butterfly_pkg::*;
#(
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int WORDS_PER_FRAME = DEF_WORDS_PER_FRAME
) (
    input  logic                 Clock,
    input  logic                 nReset,
`ifdef BUTTERFLY_TX_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 in_valid,
    input  logic [OPERAND_W-1:0] in_data,
    output logic                 in_ready,
    output logic [OPERAND_W-1:0] tx_data,
    output logic                 tx_ready,
    output logic [2:0]           word_idx,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int PH_W  = $clog2(max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES)) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_IDX = 3'(WORDS_PER_FRAME - 1);

    tx_state_t            state, state_nxt;
    logic [PH_W-1:0]      phase, phase_nxt;
    logic [CNT_W-1:0]     fifo_count;
    logic [OPERAND_W-1:0] fifo_head;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop, gap_exit;
    logic                 flush_now, flushed;

`ifdef BUTTERFLY_TX_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign in_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready && !fifo_full;
    assign busy     = (state != IDLE);

    operand_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OPERAND_W)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (nReset),
        .clear   (flush_now),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state, phase reload/decrement and pop decision.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        pop       = 1'b0;
        gap_exit  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !flush_now) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                    phase_nxt = PH_W'(SETUP_CYCLES);
                end
            end
            SETUP: begin
                if (flush_now) begin
                    state_nxt = IDLE;
                end else if (phase == PH_W'(1)) begin
                    state_nxt = HOLD;
                    phase_nxt = PH_W'(HOLD_CYCLES);
                end else begin
                    phase_nxt = phase - PH_W'(1);
                end
            end
            HOLD: begin
                if (phase == PH_W'(1)) begin
                    state_nxt = GAP;
                    phase_nxt = PH_W'(GAP_CYCLES);
                end else begin
                    phase_nxt = phase - PH_W'(1);
                end
            end
            GAP: begin
                if (phase == PH_W'(1)) begin
                    state_nxt = IDLE;
                    gap_exit  = 1'b1;
                end else begin
                    phase_nxt = phase - PH_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output registers: tx_ready follows the registered HOLD state, so it cannot glitch.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            phase      <= '0;
            tx_data    <= '0;
            tx_ready   <= 1'b0;
            word_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            phase      <= phase_nxt;
            tx_ready   <= (state_nxt == HOLD);
            frame_done <= 1'b0;
            if (pop) tx_data <= fifo_head;
            if (flush_now) begin
                word_idx <= '0;
            end else if (gap_exit && !flushed) begin
                if (word_idx == LAST_IDX) begin
                    word_idx   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    word_idx <= word_idx + 3'd1;
                end
            end
        end
    end

`ifdef BUTTERFLY_TX_FLUSH_EN
    // Remember a flush that landed mid-pulse so that word does not count toward the frame.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)                                       flushed <= 1'b0;
        else if (gap_exit)                                 flushed <= 1'b0;
        else if (flush_now && (state == HOLD || state == GAP)) flushed <= 1'b1;
    end
`else
    assign flushed = 1'b0;
`endif

endmodule

// File: tb/tb_butterfly_operand_tx.sv
// tb_butterfly_operand_tx: scoreboard bench for butterfly_operand_tx. Accepted
// pushes go into exp_q; each tx_ready rising edge consumes the next entry.
module tb_butterfly_operand_tx;
    localparam int S = 2;
    localparam int H = 16;
    localparam int G = 16;
    localparam int W = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, tx_ready, busy, frame_done;
    logic [7:0] tx_data;
    logic [2:0] word_idx;

    logic       f_valid = 1'b0;
    logic [7:0] f_data = 8'h00;
    logic       f_in_ready, f_tx_ready, f_busy, f_frame_done;
    logic [7:0] f_tx_data;
    logic [2:0] f_word_idx;

`ifdef BUTTERFLY_TX_FLUSH_EN
    logic       flush = 1'b0;
`endif

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         skip_to = 0;
    int         epoch = 0;
    bit         mon_en = 1'b1;
    int         rd_i = 0;
    int         seen_epoch = 0;
    int         done_cnt = 0;
    int         fd_cnt = 0;
    int         hi_len = 0;
    int         low_len = 0;
    logic       prev_rdy = 1'b0;
    logic [7:0] cur_data = 8'h00;

    always #5 clk = ~clk;

    butterfly_operand_tx dut (
        .Clock      (clk),
        .nReset     (rst_n),
`ifdef BUTTERFLY_TX_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .word_idx   (word_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    butterfly_operand_tx #(
        .SETUP_CYCLES (1),
        .HOLD_CYCLES  (1),
        .GAP_CYCLES   (1)
    ) dut_fast (
        .Clock      (clk),
        .nReset     (rst_n),
`ifdef BUTTERFLY_TX_FLUSH_EN
        .flush      (1'b0),
`endif
        .in_valid   (f_valid),
        .in_data    (f_data),
        .in_ready   (f_in_ready),
        .tx_data    (f_tx_data),
        .tx_ready   (f_tx_ready),
        .word_idx   (f_word_idx),
        .busy       (f_busy),
        .frame_done (f_frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d, output int waited);
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready) exp_q.push_back(d);
        else          chk("push_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((busy || rd_i != exp_q.size()) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < max_cyc, 1);
        @(negedge clk);
    endtask

    task automatic new_epoch();
        skip_to = exp_q.size();
        epoch++;
    endtask

    // Scoreboard monitor for the default-timing instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                rd_i       = skip_to;
                done_cnt   = 0;
                hi_len     = 0;
                low_len    = 0;
            end else if (tx_ready && !prev_rdy) begin
                if (done_cnt > 0) chk("gap_len_min", low_len >= G, 1);
                if (rd_i >= exp_q.size()) begin
                    chk("unexpected_pulse", rd_i, exp_q.size());
                end else begin
                    chk("tx_data", tx_data, exp_q[rd_i]);
                    rd_i++;
                end
                chk("word_idx", word_idx, done_cnt % W);
                cur_data = tx_data;
                hi_len   = 1;
            end else if (!tx_ready && prev_rdy) begin
                chk("hold_len", hi_len, H);
                chk("tx_data_stable", tx_data, cur_data);
                done_cnt++;
                low_len = 1;
            end else if (tx_ready) begin
                hi_len++;
            end else begin
                low_len++;
            end
            if (frame_done) begin
                fd_cnt++;
                chk("fd_word_idx", word_idx, 0);
                chk("fd_frame_pos", done_cnt % W, 0);
            end
            prev_rdy = tx_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, lat, fd0, seen;
        int f_last, f_k, f_cyc;
        logic f_prev;

        #1;
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_word_idx", word_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Full frame of six back-to-back words.
        fd0 = fd_cnt;
        for (int i = 1; i <= 6; i++) push_word(8'(i), waited);
        wait_drain("frame_drain", 600);
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("idx_after_frame", word_idx, 0);

        // Single word into an empty FIFO: push-to-tx_ready latency.
        push_word(8'h5A, waited);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!tx_ready && lat < 60);
        chk("latency", lat, S + 2);
        chk("latency_data", tx_data, 8'h5A);
        wait_drain("single_drain", 200);
        chk("idx_after_single", word_idx, 1);

        // Overflow: one word in flight, eight fill the FIFO, ninth must wait.
        push_word(8'h80, waited);
        repeat (2) @(negedge clk);
        chk("busy_in_flight", busy, 1);
        for (int i = 1; i <= 8; i++) push_word(8'(8'h80 + i), waited);
        @(negedge clk);
        chk("in_ready_full", in_ready, 0);
        push_word(8'h89, waited);
        chk("ninth_held", waited > 0, 1);
        wait_drain("overflow_drain", 800);
        chk("idx_after_overflow", word_idx, 5);

        // Reset during the fifth HOLD cycle with words still queued.
        push_word(8'hA1, waited);
        push_word(8'hA2, waited);
        push_word(8'hA3, waited);
        seen = 0;
        while (!tx_ready && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        chk("reset_pulse_seen", tx_ready, 1);
        repeat (4) @(negedge clk);
        chk("reset_pre_idx_nonzero", word_idx != 0, 1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx_ready", tx_ready, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_tx_data", tx_data, 0);
        chk("rst_mid_word_idx", word_idx, 0);
        chk("rst_mid_frame_done", frame_done, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        new_epoch();
        mon_en = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | int'(busy);
        end
        chk("fifo_empty_after_rst", seen, 0);
        push_word(8'hC3, waited);
        wait_drain("post_reset_drain", 200);
        chk("idx_after_reset_word", word_idx, 1);

`ifdef BUTTERFLY_TX_FLUSH_EN
        // Flush while in SETUP: no pulse, frame position cleared.
        push_word(8'hD1, waited);
        @(negedge clk);
        @(negedge clk);
        chk("flush_setup_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            seen = seen | int'(tx_ready);
        end
        chk("flush_setup_no_pulse", seen, 0);
        chk("flush_setup_idx", word_idx, 0);
        chk("flush_setup_busy_after", busy, 0);
        new_epoch();
        @(negedge clk);

        // Flush during the last word's HOLD: pulse completes, no frame_done.
        for (int i = 0; i < 6; i++) push_word(8'(8'hE0 + i), waited);
        seen = 0;
        while (!(tx_ready && word_idx == 3'd5) && seen < 400) begin
            @(negedge clk);
            seen++;
        end
        chk("flush_hold_reached", seen < 400, 1);
        fd0 = fd_cnt;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_drain("flush_hold_drain", 200);
        chk("flush_hold_no_frame_done", fd_cnt - fd0, 0);
        chk("flush_hold_idx", word_idx, 0);
        new_epoch();
        @(negedge clk);
`endif

        // Minimum timing instance: one pulse every four cycles.
        f_last = 0;
        f_k    = 0;
        f_cyc  = 0;
        f_prev = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    f_valid = 1'b1;
                    f_data  = 8'(8'h10 + i);
                    @(posedge clk);
                    #1;
                    f_valid = 1'b0;
                end
            end
            begin
                while (f_k < 6 && f_cyc < 80) begin
                    @(negedge clk);
                    f_cyc++;
                    if (f_tx_ready && !f_prev) begin
                        chk("fast_data", f_tx_data, 32'h10 + f_k);
                        if (f_k > 0) chk("fast_period", f_cyc - f_last, 4);
                        f_last = f_cyc;
                        f_k++;
                    end
                    f_prev = f_tx_ready;
                end
            end
        join
        chk("fast_pulse_count", f_k, 6);
        chk("scoreboard_empty", rd_i, exp_q.size());

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
